// File: rtl/cmd_dispatch.sv
// Command dispatcher: fans one tagged command stream into independent AES and SHA
// first-word-fall-through address FIFOs. Optional macro CMD_DISPATCH_ERR_CNT_EN adds a dropped-command counter.
module cmd_dispatch #(
    parameter int ADDRW  = 24,
    parameter int QDEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_in,
    input  logic [1:0]                       target_in,
    input  logic [ADDRW-1:0]                 addr_in,
    output logic                             ready_out,
    output logic                             valid_out_aes,
    output logic [ADDRW-1:0]                 addr_out_aes,
    input  logic                             ready_in_aes,
    output logic                             valid_out_sha,
    output logic [ADDRW-1:0]                 addr_out_sha,
    input  logic                             ready_in_sha,
    output logic [$clog2(QDEPTH+1)-1:0]      count_aes,
    output logic [$clog2(QDEPTH+1)-1:0]      count_sha,
    output logic                             err_pulse,
    output logic [7:0]                       err_count
);

    localparam int CW = $clog2(QDEPTH+1);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [CW-1:0] FULLCNT = CW'(QDEPTH);

    logic [ADDRW-1:0] r_memAes [QDEPTH];
    logic [ADDRW-1:0] r_memSha [QDEPTH];
    logic [PW-1:0]    r_headAes, r_tailAes, r_headSha, r_tailSha;
    logic [CW-1:0]    r_cntAes, r_cntSha;
    logic             r_errPulse;

    logic w_fullAes, w_fullSha;
    logic w_pushAes, w_pushSha, w_popAes, w_popSha, w_drop;

    assign w_fullAes = (r_cntAes == FULLCNT);
    assign w_fullSha = (r_cntSha == FULLCNT);

    // Readiness depends only on the addressed FIFO, so a full engine never stalls the other.
    always_comb begin
        ready_out = 1'b1;
        case (target_in)
            2'b00:   ready_out = !w_fullAes;
            2'b01:   ready_out = !w_fullSha;
            default: ready_out = 1'b1;
        endcase
    end

    assign w_pushAes = valid_in && ready_out && (target_in == 2'b00);
    assign w_pushSha = valid_in && ready_out && (target_in == 2'b01);
    assign w_drop    = valid_in && target_in[1];
    assign w_popAes  = (r_cntAes != '0) && ready_in_aes;
    assign w_popSha  = (r_cntSha != '0) && ready_in_sha;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_headAes <= '0;
            r_tailAes <= '0;
            r_cntAes  <= '0;
        end else begin
            if (w_pushAes) r_tailAes <= r_tailAes + 1'b1;
            if (w_popAes)  r_headAes <= r_headAes + 1'b1;
            case ({w_pushAes, w_popAes})
                2'b10:   r_cntAes <= r_cntAes + 1'b1;
                2'b01:   r_cntAes <= r_cntAes - 1'b1;
                default: r_cntAes <= r_cntAes;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_headSha <= '0;
            r_tailSha <= '0;
            r_cntSha  <= '0;
        end else begin
            if (w_pushSha) r_tailSha <= r_tailSha + 1'b1;
            if (w_popSha)  r_headSha <= r_headSha + 1'b1;
            case ({w_pushSha, w_popSha})
                2'b10:   r_cntSha <= r_cntSha + 1'b1;
                2'b01:   r_cntSha <= r_cntSha - 1'b1;
                default: r_cntSha <= r_cntSha;
            endcase
        end
    end

    // Storage is deliberately left out of reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_pushAes) r_memAes[r_tailAes] <= addr_in;
        if (w_pushSha) r_memSha[r_tailSha] <= addr_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_errPulse <= 1'b0;
        else        r_errPulse <= w_drop;
    end

`ifdef CMD_DISPATCH_ERR_CNT_EN
    logic [7:0] r_errCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_errCount <= 8'h00;
        else if (w_drop && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'h01;
    end

    assign err_count = r_errCount;
`else
    assign err_count = 8'h00;
`endif

    assign err_pulse     = r_errPulse;
    assign valid_out_aes = (r_cntAes != '0);
    assign valid_out_sha = (r_cntSha != '0);
    assign addr_out_aes  = r_memAes[r_headAes];
    assign addr_out_sha  = r_memSha[r_headSha];
    assign count_aes     = r_cntAes;
    assign count_sha     = r_cntSha;

endmodule
